// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the instruction encoder/loader.
//   mnem_t   : mnemonic codes accepted on the command stream (codes 19..31 illegal)
//   fmt_t    : operand format, selects which register/immediate fields are kept
//   state_t  : loader FSM states
//   pack_instr(): assembles the 32-bit word from its fields
// Word layout, LSB first: opcode[2:0] funct2[4:3] rd[8:5] rs1[12:9] rs2[16:13] imm[31:17].
package isa_pkg;

    typedef enum logic [4:0] {
        MN_ADDP  = 5'd0,
        MN_SUBP  = 5'd1,
        MN_MULP  = 5'd2,
        MN_DIVP  = 5'd3,
        MN_ANDP  = 5'd4,
        MN_ORP   = 5'd5,
        MN_CMPP  = 5'd6,
        MN_ADDIP = 5'd7,
        MN_SLLIP = 5'd8,
        MN_SRLIP = 5'd9,
        MN_LB    = 5'd10,
        MN_LW    = 5'd11,
        MN_SB    = 5'd12,
        MN_SW    = 5'd13,
        MN_BLTP  = 5'd14,
        MN_BGEP  = 5'd15,
        MN_JUMP  = 5'd16,
        MN_NOP   = 5'd17,
        MN_END   = 5'd18
    } mnem_t;

    // R: rd,rs1,rs2   I: rd,rs1,imm   SB: rs1,rs2,imm   J: imm only   NONE: no operands
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SB,
        FMT_J,
        FMT_NONE
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [2:0] OP_ARITH  = 3'b000;
    localparam logic [2:0] OP_LOGIC  = 3'b001;
    localparam logic [2:0] OP_IMM    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_STORE  = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;

    localparam int unsigned OPC_LSB  = 0;
    localparam int unsigned F2_LSB   = 3;
    localparam int unsigned RD_LSB   = 5;
    localparam int unsigned RS1_LSB  = 9;
    localparam int unsigned RS2_LSB  = 13;
    localparam int unsigned IMM_LSB  = 17;
    localparam int unsigned IMM_BITS = 15;

    function automatic logic [31:0] pack_instr(
        input logic [2:0]          op,
        input logic [1:0]          f2,
        input logic [3:0]          rd,
        input logic [3:0]          rs1,
        input logic [3:0]          rs2,
        input logic [IMM_BITS-1:0] imm
    );
        return (32'(op)  << OPC_LSB) |
               (32'(f2)  << F2_LSB)  |
               (32'(rd)  << RD_LSB)  |
               (32'(rs1) << RS1_LSB) |
               (32'(rs2) << RS2_LSB) |
               (32'(imm) << IMM_LSB);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// instr_encode: combinational mnemonic + operand fields -> instruction word.
//   mnem_i    : mnemonic code (isa_pkg::mnem_t)
//   rd_i/rs1_i/rs2_i : register fields
//   imm_i     : signed 16-bit immediate, low 15 bits are encoded
//   word_o    : encoded instruction (unused operand fields forced to zero)
//   legal_o   : mnemonic is one of the defined codes (END included)
//   trunc_o   : the immediate is used by this mnemonic and does not fit 15 bits signed
module instr_encode
    import isa_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rs1_i,
    input  logic [3:0]  rs2_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o,
    output logic        trunc_o
);

    logic [2:0] op;
    logic [1:0] f2;
    fmt_t       fmt;
    logic       use_rd, use_rs1, use_rs2, use_imm;

    always_comb begin
        op      = '0;
        f2      = '0;
        fmt     = FMT_NONE;
        legal_o = 1'b1;
        case (mnem_i)
            MN_ADDP:  begin op = OP_ARITH;  f2 = 2'd0; fmt = FMT_R;  end
            MN_SUBP:  begin op = OP_ARITH;  f2 = 2'd1; fmt = FMT_R;  end
            MN_MULP:  begin op = OP_ARITH;  f2 = 2'd2; fmt = FMT_R;  end
            MN_DIVP:  begin op = OP_ARITH;  f2 = 2'd3; fmt = FMT_R;  end
            MN_ANDP:  begin op = OP_LOGIC;  f2 = 2'd0; fmt = FMT_R;  end
            MN_ORP:   begin op = OP_LOGIC;  f2 = 2'd1; fmt = FMT_R;  end
            MN_CMPP:  begin op = OP_LOGIC;  f2 = 2'd2; fmt = FMT_R;  end
            MN_ADDIP: begin op = OP_IMM;    f2 = 2'd0; fmt = FMT_I;  end
            MN_SLLIP: begin op = OP_IMM;    f2 = 2'd1; fmt = FMT_I;  end
            MN_SRLIP: begin op = OP_IMM;    f2 = 2'd2; fmt = FMT_I;  end
            MN_LB:    begin op = OP_LOAD;   f2 = 2'd0; fmt = FMT_I;  end
            MN_LW:    begin op = OP_LOAD;   f2 = 2'd1; fmt = FMT_I;  end
            MN_SB:    begin op = OP_STORE;  f2 = 2'd0; fmt = FMT_SB; end
            MN_SW:    begin op = OP_STORE;  f2 = 2'd1; fmt = FMT_SB; end
            MN_BLTP:  begin op = OP_BRANCH; f2 = 2'd0; fmt = FMT_SB; end
            MN_BGEP:  begin op = OP_BRANCH; f2 = 2'd1; fmt = FMT_SB; end
            MN_JUMP:  begin op = OP_BRANCH; f2 = 2'd2; fmt = FMT_J;  end
            // NOP is addip r0,r0,0: only the opcode survives
            MN_NOP:   begin op = OP_IMM;    f2 = 2'd0; fmt = FMT_NONE; end
            MN_END:   begin fmt = FMT_NONE; end
            default:  begin legal_o = 1'b0; end
        endcase
    end

    assign use_rd  = (fmt == FMT_R) || (fmt == FMT_I);
    assign use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_SB);
    assign use_rs2 = (fmt == FMT_R) || (fmt == FMT_SB);
    assign use_imm = (fmt == FMT_I) || (fmt == FMT_SB) || (fmt == FMT_J);

    // A 16-bit value fits 15 bits signed iff its top two bits agree
    assign trunc_o = use_imm && (imm_i[15] != imm_i[14]);

    assign word_o = pack_instr(op, f2,
                               use_rd  ? rd_i  : 4'd0,
                               use_rs1 ? rs1_i : 4'd0,
                               use_rs2 ? rs2_i : 4'd0,
                               use_imm ? imm_i[IMM_BITS-1:0] : '0);

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts mnemonic commands over valid/ready, encodes them and
// writes the words sequentially into instruction memory while holding the core in reset.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse, (re)starts a load session from BASE_ADDR
//   cmd_*             : command stream (cmd_ready high only while loading)
//   imem_we/addr/wdata: registered write port, one cycle after acceptance
//   core_rst_n, done  : high only once END has been accepted
//   error             : illegal mnemonic or memory overflow (cleared by start)
//   imm_trunc         : sticky, an encoded immediate did not fit 15 bits signed
//   instr_count       : words written this session
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [4:0]                    cmd_mnem,
    input  logic [3:0]                    cmd_rd,
    input  logic [3:0]                    cmd_rs1,
    input  logic [3:0]                    cmd_rs2,
    input  logic [15:0]                   cmd_imm,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [INSTR_W-1:0]            imem_wdata,
    output logic                          core_rst_n,
    output logic                          done,
    output logic                          error,
    output logic                          imm_trunc,
    output logic [$clog2(IMEM_DEPTH):0]   instr_count
);

    localparam int unsigned AW      = $clog2(IMEM_DEPTH);
    localparam logic [AW:0] DEPTH_A = (AW+1)'(IMEM_DEPTH);
    localparam logic [AW:0] BASE_A  = (AW+1)'(BASE_ADDR);

    state_t             state_q, state_d;
    logic [AW:0]        addr_q;
    logic [AW:0]        count_q;
    logic [AW-1:0]      waddr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               we_q;
    logic               error_q;
    logic               trunc_q;

    logic               accept;
    logic               do_write;
    logic               err_set;
    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               enc_trunc;

    instr_encode u_encode (
        .mnem_i  (cmd_mnem),
        .rd_i    (cmd_rd),
        .rs1_i   (cmd_rs1),
        .rs2_i   (cmd_rs2),
        .imm_i   (cmd_imm),
        .word_o  (enc_word),
        .legal_o (enc_legal),
        .trunc_o (enc_trunc)
    );

    // A restart pulse takes precedence, so a command presented alongside it is
    // held off rather than accepted and silently discarded.
    assign cmd_ready = (state_q == ST_LOAD) && !start;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (!enc_legal) begin
                        state_d = ST_ERR;
                        err_set = 1'b1;
                    end else if (cmd_mnem == MN_END) begin
                        state_d = ST_DONE;
                    end else if (addr_q == DEPTH_A) begin
                        state_d = ST_ERR;
                        err_set = 1'b1;
                    end else begin
                        do_write = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            error_q <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            // we_q reflects only the previous cycle's accept, so a write in flight
            // when start arrives still completes.
            we_q <= do_write;
            if (do_write) begin
                waddr_q <= addr_q[AW-1:0];
                wdata_q <= INSTR_W'(enc_word);
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q + 1'b1;
                if (enc_trunc) trunc_q <= 1'b1;
            end
            if (err_set) error_q <= 1'b1;
            if (start) begin
                addr_q  <= BASE_A;
                count_q <= '0;
                error_q <= 1'b0;
                trunc_q <= 1'b0;
            end
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign core_rst_n  = (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign imm_trunc   = trunc_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed vector table, hand-written
// corner sequences and a randomized stream checked against a field-arithmetic model.
module tb_instr_encoder_loader;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [4:0]  cmd_mnem = '0;
    logic [3:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [15:0] cmd_imm = '0;

    logic        m_ready, m_we, m_core, m_done, m_err, m_trunc;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [8:0]  m_count;

    logic        s_ready, s_we, s_core, s_done, s_err, s_trunc;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(m_ready),
        .cmd_mnem(cmd_mnem), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
        .core_rst_n(m_core), .done(m_done), .error(m_err), .imm_trunc(m_trunc),
        .instr_count(m_count)
    );

    instr_encoder_loader #(.IMEM_DEPTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(s_ready),
        .cmd_mnem(cmd_mnem), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .core_rst_n(s_core), .done(s_done), .error(s_err), .imm_trunc(s_trunc),
        .instr_count(s_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;
    wr_t m_obs[$];
    wr_t s_obs[$];

    always @(negedge clk) begin
        if (m_we === 1'b1) m_obs.push_back('{int'(m_addr), m_wdata});
        if (s_we === 1'b1) s_obs.push_back('{int'(s_addr), s_wdata});
    end

    // Reference tables indexed by mnemonic code 0..17.
    // fmt: 0 = rd,rs1,rs2  1 = rd,rs1,imm  2 = rs1,rs2,imm  3 = imm only  4 = nothing
    int op_tab [18]  = '{0,0,0,0, 1,1,1, 2,2,2, 3,3, 4,4, 5,5,5, 2};
    int f2_tab [18]  = '{0,1,2,3, 0,1,2, 0,1,2, 0,1, 0,1, 0,1,2, 0};
    int fmt_tab [18] = '{0,0,0,0, 0,0,0, 1,1,1, 1,1, 2,2, 2,2,3, 4};

    function automatic logic [31:0] ref_word(input int mn, input int rd, input int rs1,
                                             input int rs2, input int imm);
        int unsigned w;
        int f;
        f = fmt_tab[mn];
        w = op_tab[mn] + 8 * f2_tab[mn];
        if (f == 0 || f == 1) w += 32 * rd;
        if (f <= 2) w += 512 * rs1;
        if (f == 0 || f == 2) w += 8192 * rs2;
        if (f >= 1 && f <= 3) w += 131072 * (imm % 32768);
        return w;
    endfunction

    function automatic bit ref_trunc(input int mn, input int imm);
        int f;
        f = fmt_tab[mn];
        // representable 15-bit signed range is -16384..16383
        return (f >= 1 && f <= 3) && (imm >= 16384 && imm < 49152);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input int mn, input int rd, input int rs1, input int rs2, input int imm);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mnem  = 5'(mn);
        cmd_rd    = 4'(rd);
        cmd_rs1   = 4'(rs1);
        cmd_rs2   = 4'(rs2);
        cmd_imm   = 16'(imm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_start();
        @(negedge clk);
        cmd_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, m_ready, 0);
        chk({tag, "_we"}, m_we, 0);
        chk({tag, "_addr"}, m_addr, 0);
        chk({tag, "_wdata"}, m_wdata, 0);
        chk({tag, "_core_rst_n"}, m_core, 0);
        chk({tag, "_flags"}, {m_done, m_err, m_trunc}, 0);
        chk({tag, "_count"}, m_count, 0);
    endtask

    typedef struct {
        int mn; int rd; int rs1; int rs2; int imm;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int drops;
        logic [31:0] exp_q[$];
        bit exp_tr;
        int mn, rd, rs1, rs2, imm;

        vecs[0]  = '{int'(MN_ADDP),  1, 2, 3, 4, 32'h0000_6420};
        vecs[1]  = '{int'(MN_SUBP),  1, 2, 3, 4, 32'h0000_6428};
        vecs[2]  = '{int'(MN_MULP),  1, 2, 3, 4, 32'h0000_6430};
        vecs[3]  = '{int'(MN_DIVP),  1, 2, 3, 4, 32'h0000_6438};
        vecs[4]  = '{int'(MN_ANDP),  1, 2, 3, 4, 32'h0000_6421};
        vecs[5]  = '{int'(MN_ORP),   1, 2, 3, 4, 32'h0000_6429};
        vecs[6]  = '{int'(MN_CMPP),  1, 2, 3, 4, 32'h0000_6431};
        vecs[7]  = '{int'(MN_ADDIP), 1, 2, 3, 4, 32'h0008_0422};
        vecs[8]  = '{int'(MN_SLLIP), 1, 2, 3, 4, 32'h0008_042A};
        vecs[9]  = '{int'(MN_SRLIP), 1, 2, 3, 4, 32'h0008_0432};
        vecs[10] = '{int'(MN_LB),    1, 2, 3, 4, 32'h0008_0423};
        vecs[11] = '{int'(MN_LW),    1, 2, 3, 4, 32'h0008_042B};
        vecs[12] = '{int'(MN_SB),    1, 2, 3, 4, 32'h0008_6404};
        vecs[13] = '{int'(MN_SW),    1, 2, 3, 4, 32'h0008_640C};
        vecs[14] = '{int'(MN_BLTP),  1, 2, 3, 4, 32'h0008_6405};
        vecs[15] = '{int'(MN_BGEP),  1, 2, 3, 4, 32'h0008_640D};
        vecs[16] = '{int'(MN_JUMP),  1, 2, 3, 4, 32'h0008_0015};
        vecs[17] = '{int'(MN_NOP),   1, 2, 3, 4, 32'h0000_0002};

        // reset state
        #3;
        chk_reset("rst");
        chk("rst_small", {s_ready, s_we, s_core, s_done, s_err, s_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // addip r1,r0,5 then END: write in the cycle after acceptance
        do_start();
        m_obs.delete();
        send(int'(MN_ADDIP), 1, 0, 0, 5);
        @(negedge clk);
        chk("lat_we", m_we, 1);
        chk("lat_addr", m_addr, 0);
        chk("lat_wdata", m_wdata, 32'h000A_0022);
        chk("lat_core_held", m_core, 0);
        cmd_mnem = 5'(int'(MN_END));
        idle(2);
        chk("end_done", m_done, 1);
        chk("end_core_rst_n", m_core, 1);
        chk("end_count", m_count, 1);
        chk("end_ready", m_ready, 0);
        chk("end_writes", m_obs.size(), 1);

        // all mnemonics back to back
        do_start();
        m_obs.delete();
        drops = 0;
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].mn, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            #1;
            if (m_ready !== 1'b1) drops++;
        end
        idle(2);
        chk("stream_ready_drops", drops, 0);
        chk("stream_writes", m_obs.size(), 18);
        for (int i = 0; i < 18 && i < m_obs.size(); i++) begin
            chk($sformatf("stream_addr%0d", i), m_obs[i].addr, i);
            chk($sformatf("stream_word%0d", i), m_obs[i].data, vecs[i].exp);
        end
        chk("stream_count", m_count, 18);

        // immediate range boundaries
        do_start();
        m_obs.delete();
        send(int'(MN_ADDIP), 0, 0, 0, 'h3FFF);
        send(int'(MN_ADDIP), 0, 0, 0, 'hC000);
        idle(1);
        chk("trunc_inrange", m_trunc, 0);
        send(int'(MN_ADDIP), 0, 0, 0, 'h4000);
        idle(1);
        chk("trunc_set", m_trunc, 1);
        send(int'(MN_ADDIP), 0, 0, 0, 1);
        idle(2);
        chk("trunc_sticky", m_trunc, 1);
        chk("trunc_session_live", m_ready, 1);
        chk("trunc_writes", m_obs.size(), 4);
        if (m_obs.size() == 4) begin
            chk("trunc_w0", m_obs[0].data, 32'h7FFE_0002);
            chk("trunc_w1", m_obs[1].data, 32'h8000_0002);
            chk("trunc_w2", m_obs[2].data, 32'h8000_0002);
            chk("trunc_w3", m_obs[3].data, 32'h0002_0002);
        end

        // overflow on the 4-word instance
        do_start();
        s_obs.delete();
        for (int i = 0; i < 5; i++) send(int'(MN_ADDIP), i + 1, 0, 0, 0);
        idle(2);
        chk("ovf_writes", s_obs.size(), 4);
        for (int i = 0; i < 4 && i < s_obs.size(); i++)
            chk($sformatf("ovf_addr%0d", i), s_obs[i].addr, i);
        chk("ovf_error", s_err, 1);
        chk("ovf_core_rst_n", s_core, 0);
        chk("ovf_done", s_done, 0);
        chk("ovf_count", s_count, 4);
        chk("ovf_ready", s_ready, 0);

        // illegal mnemonic then restart
        do_start();
        m_obs.delete();
        send(int'(MN_ADDIP), 2, 0, 0, 0);
        send(31, 1, 1, 1, 1);
        idle(2);
        chk("ill_writes", m_obs.size(), 1);
        chk("ill_error", m_err, 1);
        chk("ill_core_rst_n", m_core, 0);
        chk("ill_ready", m_ready, 0);
        do_start();
        #1;
        chk("ill_restart_error", m_err, 0);
        chk("ill_restart_ready", m_ready, 1);
        chk("ill_restart_count", m_count, 0);
        m_obs.delete();
        send(int'(MN_ADDIP), 3, 0, 0, 7);
        idle(2);
        chk("ill_restart_writes", m_obs.size(), 1);
        if (m_obs.size() == 1) begin
            chk("ill_restart_addr", m_obs[0].addr, 0);
            chk("ill_restart_word", m_obs[0].data, 32'h000E_0062);
        end

        // asynchronous reset with a write pending
        do_start();
        m_obs.delete();
        for (int i = 0; i < 4; i++) send(int'(MN_ADDIP), i, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("arst_writes", m_obs.size(), 3);
        chk("arst_ready_after", m_ready, 0);
        chk("arst_count_after", m_count, 0);
        do_start();
        m_obs.delete();
        send(int'(MN_NOP), 5, 6, 7, 8);
        idle(2);
        chk("arst_resume_writes", m_obs.size(), 1);
        if (m_obs.size() == 1) chk("arst_resume_word", m_obs[0].data, 32'h0000_0002);

        // randomized stream against the model
        do_start();
        m_obs.delete();
        exp_q.delete();
        exp_tr = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                cmd_valid = 1'b0;
            end else begin
                mn  = $urandom_range(0, 17);
                rd  = $urandom_range(0, 15);
                rs1 = $urandom_range(0, 15);
                rs2 = $urandom_range(0, 15);
                imm = $urandom_range(0, 65535);
                send(mn, rd, rs1, rs2, imm);
                exp_q.push_back(ref_word(mn, rd, rs1, rs2, imm));
                if (ref_trunc(mn, imm)) exp_tr = 1;
            end
        end
        idle(2);
        chk("rand_writes", m_obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < m_obs.size(); i++) begin
            chk($sformatf("rand_addr%0d", i), m_obs[i].addr, i);
            chk($sformatf("rand_word%0d", i), m_obs[i].data, exp_q[i]);
        end
        chk("rand_count", m_count, exp_q.size());
        chk("rand_trunc", m_trunc, exp_tr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
